// File: rtl/const_link_pkg.sv
// Types and defaults shared by both ends of the constant-pattern link.
package const_link_pkg;

  localparam int          DEFAULT_DATA_BIT_WIDTH = 32;
  localparam logic [31:0] DEFAULT_VALUE          = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } checker_state_t;

endpackage

// File: rtl/const_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; count is visible one cycle after inc.
// It has no handshake: inc is a single-cycle pulse, and once the counter is all-ones, further pulses are absorbed.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/const_checker.sv
// Checks received words against a constant, locks after LOCK_COUNT matches, and makes a mismatch after lock a sticky error; status is visible 1 cycle after the word.
// in_ready drops only during rst or clear. Optional CONST_CHECKER_MASK_EN adds cmp_mask, which ignores the masked-off bits.
module const_checker
  import const_link_pkg::*;
#(
  parameter int                        DATA_BIT_WIDTH = DEFAULT_DATA_BIT_WIDTH,
  parameter logic [DATA_BIT_WIDTH-1:0] VALUE          = DATA_BIT_WIDTH'(DEFAULT_VALUE),
  parameter int                        LOCK_COUNT     = 4,
  parameter int                        CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_BIT_WIDTH-1:0] in_data,
`ifdef CONST_CHECKER_MASK_EN
  input  logic [DATA_BIT_WIDTH-1:0] cmp_mask,
`endif
  output logic                      locked,
  output logic                      error,
  output logic [CNT_WIDTH-1:0]      match_count,
  output logic [CNT_WIDTH-1:0]      mismatch_count,
  output logic [DATA_BIT_WIDTH-1:0] first_bad_data,
  output logic [1:0]                state
);

  localparam int               RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

  checker_state_t              state_q, state_d;
  logic [RUN_W-1:0]            run_q, run_d;
  logic [DATA_BIT_WIDTH-1:0]   bad_q, bad_d;
  logic                        locked_q, locked_d;
  logic                        error_q, error_d;
  logic                        accept;
  logic                        is_match;

  assign in_ready = ~rst & ~clear;
  assign accept   = in_valid & in_ready;

`ifdef CONST_CHECKER_MASK_EN
  assign is_match = (((in_data ^ VALUE) & cmp_mask) == '0);
`else
  assign is_match = (in_data == VALUE);
`endif

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    bad_d   = bad_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
      bad_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (is_match) begin
            run_d   = RUN_W'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
          end else begin
            run_d   = '0;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (is_match) begin
            run_d = run_q + RUN_W'(1);
            if (run_d >= LOCK_RUN) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!is_match) begin
            state_d = ERROR;
            bad_d   = in_data;
          end
        end
        ERROR: ;
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == LOCKED);
    error_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (accept & is_match),
    .count (match_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mismatch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (accept & ~is_match),
    .count (mismatch_count)
  );

  assign locked         = locked_q;
  assign error          = error_q;
  assign first_bad_data = bad_q;
  assign state          = state_q;

endmodule

// File: doc/const_checker.md
Name: const_checker

Overview:
- Receive end of the constant-pattern link: consumes the data word stream produced by the constant driver and checks every accepted word against the expected constant.
- Acquires lock after a run of consecutive matches, then flags any later mismatch as a sticky error.
- Counts matches and mismatches and captures the first bad word, for readback by the system-integration test logic.

Parameters:
- DATA_BIT_WIDTH, 32, width of the checked data word
- VALUE, 32'hDEADBEEF, expected constant; must match the driver's VALUE
- LOCK_COUNT, 4, consecutive matches required to declare lock (>=1)
- CNT_WIDTH, 16, width of the match/mismatch counters

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous soft clear of all status; returns to IDLE
- in_valid  input  1  in_data holds a word this cycle
- in_ready  output  1  checker accepts a word this cycle
- in_data  input  DATA_BIT_WIDTH  received data word
- locked  output  1  high while state == LOCKED
- error  output  1  sticky; high while state == ERROR
- match_count  output  CNT_WIDTH  accepted words equal to VALUE, saturating
- mismatch_count  output  CNT_WIDTH  accepted words not equal to VALUE, saturating
- first_bad_data  output  DATA_BIT_WIDTH  first mismatching word accepted in LOCKED
- state  output  2  current FSM state encoding

Behaviour:
- Reset (asynchronous, rst=1) sets all outputs as follows:
  - state=IDLE, locked=0, error=0.
  - Both counters 0, first_bad_data=0.
  - Internal run counter 0.
  - in_ready=0 while rst=1.
- in_ready is 1 whenever rst=0 and clear=0; it is registered-free, driven combinationally from these two inputs.
- A word is accepted when in_valid && in_ready.
- Accepted words update all outputs at that same edge, so the result is visible the next cycle (1-cycle latency).
- A word matches when in_data == VALUE, compared over the full width.
- Each accepted word increments either match_count or mismatch_count.
  - Both counters saturate at all-ones; there is no wrap.
- FSM state encoding: IDLE=0, ACQUIRE=1, LOCKED=2, ERROR=3.
- IDLE:
  - accepted match -> run=1; go to LOCKED if LOCK_COUNT==1, else ACQUIRE.
  - accepted mismatch -> go to ACQUIRE with run=0.
- ACQUIRE:
  - match -> run+1; on reaching LOCK_COUNT go to LOCKED.
  - mismatch -> run=0, stay in ACQUIRE; error is not set.
- LOCKED:
  - match -> stay.
  - mismatch -> go to ERROR and capture in_data into first_bad_data.
- ERROR:
  - Terminal until clear or rst.
  - Counters keep counting; first_bad_data is not overwritten.
- clear=1 at an edge:
  - Same effect as reset, except in_ready is driven 0 for that cycle.
  - Any in_valid in that cycle is not accepted; the word is dropped.
- Idle cycles (in_valid=0) do not break the run; only accepted words advance the FSM.
- Reset asserted mid-run aborts immediately, without waiting for a clock edge.

Optional Feature:
- Macro: CONST_CHECKER_MASK_EN.
- Defined:
  - Adds input port cmp_mask [DATA_BIT_WIDTH-1:0].
  - A word matches when ((in_data ^ VALUE) & cmp_mask) == 0.
  - Masked-off bits are ignored.
  - first_bad_data still captures the raw, unmasked word.
- Undefined:
  - No cmp_mask port.
  - Full-width compare as described in Behaviour.

Decomposition:
- Package const_link_pkg holds:
  - DEFAULT_DATA_BIT_WIDTH=32 and DEFAULT_VALUE=32'hDEADBEEF, shared with the driver.
  - typedef enum logic [1:0] checker_state_t {IDLE, ACQUIRE, LOCKED, ERROR}.
- One sub-module: sat_counter.
  - Parameter WIDTH.
  - Ports: clk, rst, clr, inc, count.
  - Saturating increment.
  - Instantiated twice, for the match and mismatch counts.

Test Plan:
- Reset, then in_valid=1 with in_data=32'hDEADBEEF for 4 cycles:
  - locked=1 the cycle after the 4th accepted word.
  - match_count=4, mismatch_count=0, state=2.
- Stream DEADBEEF x2, then 32'h0, then DEADBEEF x4:
  - State stays ACQUIRE with no error; locked=1 after the final word.
  - match_count=6, mismatch_count=1.
- Once locked, send 32'hDEADBEEE, then 32'h12345678:
  - error=1, state=3, first_bad_data=32'hDEADBEEE (not overwritten by the second word).
  - mismatch_count=2.
- In ERROR, assert clear with in_valid=1 and in_data=DEADBEEF in the same cycle:
  - in_ready=0 that cycle.
  - Next cycle all counts are 0, state=0, error=0.
- CNT_WIDTH=4, 20 matching words: match_count holds 4'hF; no wrap.
- Assert rst asynchronously between edges while LOCKED:
  - locked, error and both counts drop to 0 before the next rising edge.
  - With CONST_CHECKER_MASK_EN defined and cmp_mask=32'hFFFF0000, in_data=32'hDEAD0000 counts as a match.
